// File: rtl/regfile_sb_if.sv
// regfile_sb_if
// Bundles the register-file buses between decode/writeback and regfile_sb.
//   Read side  : Rs, Rt -> Rout1, Rout2, busy1, busy2, hazard
//   Write side : wr, Rd, RW (a write also retires the pending flag of Rd)
//   Issue side : issue, issue_rd (marks a register as awaiting a write)
//   Status     : pend_cnt, the number of registers currently pending
// The master modport is the decode/writeback side.
// The slave modport is the register file itself.
interface regfile_sb_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic [AW-1:0] Rs;
  logic [AW-1:0] Rt;
  logic [AW-1:0] Rd;
  logic [DW-1:0] RW;
  logic          wr;
  logic          issue;
  logic [AW-1:0] issue_rd;
  logic [DW-1:0] Rout1;
  logic [DW-1:0] Rout2;
  logic          busy1;
  logic          busy2;
  logic          hazard;
  logic [AW:0]   pend_cnt;

  modport master (
    output Rs, Rt, Rd, RW, wr, issue, issue_rd,
    input  Rout1, Rout2, busy1, busy2, hazard, pend_cnt
  );

  modport slave (
    input  Rs, Rt, Rd, RW, wr, issue, issue_rd,
    output Rout1, Rout2, busy1, busy2, hazard, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb
// Parametrised two-read, one-write register file with a pending-write scoreboard.
// Ports:
//   clk : rising-edge clock for all state.
//   rst : asynchronous, active-low reset. It clears the data, the pending flags and the counter.
//   bus : regfile_sb_if.slave, which carries the following.
//     Rs/Rt    -> Rout1/Rout2 : combinational reads. An optional bypass forwards the
//                               same-cycle write data.
//     wr/Rd/RW                : the write port. A write also clears the pending flag of Rd.
//     issue/issue_rd          : sets the pending flag of issue_rd.
//     busy1/busy2/hazard      : pending status of Rs and Rt.
//     pend_cnt                : popcount of the pending flags.
// Parameters:
//   ZERO_R0 : R0 reads as 0. Writes and issues to R0 are ignored.
//   BYPASS  : a write to the register being read appears on the read port in the same cycle.
module regfile_sb #(
  parameter int DW      = 16,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    regs_reg [DEPTH];
  logic [DEPTH-1:0] pend_reg;
  logic [DEPTH-1:0] pend_next;
  logic [AW:0]      cnt_reg;
  logic [AW:0]      cnt_next;

  logic             wr_ok;
  logic             iss_ok;
  logic [DEPTH-1:0] wr_dec;
  logic [DEPTH-1:0] iss_dec;
  logic             cnt_inc;
  logic             cnt_dec;

  // Writes and issues that target a hardwired-zero R0 are dropped here.
  // All later logic can then treat R0 like any other register.
  assign wr_ok  = bus.wr    && !((ZERO_R0 != 0) && (bus.Rd == '0));
  assign iss_ok = bus.issue && !((ZERO_R0 != 0) && (bus.issue_rd == '0));

  // Per-register decode and next pending state.
  // The set is applied after the clear, so a new producer keeps ownership
  // when an issue and a write hit the same register in the same cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
    assign wr_dec[gi]    = wr_ok  && (bus.Rd == AW'(gi));
    assign iss_dec[gi]   = iss_ok && (bus.issue_rd == AW'(gi));
    assign pend_next[gi] = iss_dec[gi] | (pend_reg[gi] & ~wr_dec[gi]);
  end

  // Counter delta.
  // An issue counts only when it raises a flag that was clear.
  // A write counts only when it drops a flag that a same-cycle issue does not re-set.
  assign cnt_inc  = iss_ok && !pend_reg[bus.issue_rd];
  assign cnt_dec  = wr_ok && pend_reg[bus.Rd] && !(iss_ok && (bus.issue_rd == bus.Rd));
  assign cnt_next = cnt_reg + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
      pend_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_dec[i]) begin
          regs_reg[i] <= bus.RW;
        end
      end
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
    end
  end

  // Read ports. The bypass uses wr_ok, so a suppressed R0 write is never forwarded.
  always_comb begin
    bus.Rout1 = regs_reg[bus.Rs];
    bus.Rout2 = regs_reg[bus.Rt];
    if ((BYPASS != 0) && wr_ok && (bus.Rd == bus.Rs)) begin
      bus.Rout1 = bus.RW;
    end
    if ((BYPASS != 0) && wr_ok && (bus.Rd == bus.Rt)) begin
      bus.Rout2 = bus.RW;
    end
    if ((ZERO_R0 != 0) && (bus.Rs == '0)) begin
      bus.Rout1 = '0;
    end
    if ((ZERO_R0 != 0) && (bus.Rt == '0)) begin
      bus.Rout2 = '0;
    end
  end

  // Busy reflects the registered flags only.
  // A register being retired this cycle stays busy until the edge.
  assign bus.busy1    = pend_reg[bus.Rs];
  assign bus.busy2    = pend_reg[bus.Rt];
  assign bus.hazard   = bus.busy1 | bus.busy2;
  assign bus.pend_cnt = cnt_reg;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Directed bench for regfile_sb. It runs two instances side by side on identical stimulus:
//   dut_a : ZERO_R0=1, BYPASS=1 (the defaults)
//   dut_b : ZERO_R0=0, BYPASS=0
// Every expected value below is hand-computed from the intended behaviour.
module tb_regfile_sb;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  regfile_sb_if #(.DW(16), .AW(4)) ifa ();
  regfile_sb_if #(.DW(16), .AW(4)) ifb ();

  regfile_sb #(.DW(16), .AW(4), .ZERO_R0(1), .BYPASS(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  regfile_sb #(.DW(16), .AW(4), .ZERO_R0(0), .BYPASS(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  // The clock starts high, so rising edges fall at 10, 20, 30 ns and so on.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic w, input logic [3:0] d, input logic [15:0] data,
                     input logic iss, input logic [3:0] ird,
                     input logic [3:0] s, input logic [3:0] t);
    ifa.wr = w; ifa.Rd = d; ifa.RW = data; ifa.issue = iss; ifa.issue_rd = ird;
    ifa.Rs = s; ifa.Rt = t;
    ifb.wr = w; ifb.Rd = d; ifb.RW = data; ifb.issue = iss; ifb.issue_rd = ird;
    ifb.Rs = s; ifb.Rt = t;
  endtask

  // Advances past the next rising edge. The result lands 1 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #20;
    check("rst_a_rout1", 32'(ifa.Rout1), 0);
    check("rst_b_rout2", 32'(ifb.Rout2), 0);
    check("rst_a_cnt", 32'(ifa.pend_cnt), 0);
    check("rst_a_hazard", 32'(ifa.hazard), 0);
    #15 rst = 1'b1;                           // released at 35 ns, between edges

    // 1: write R15 after reset
    #1 drv(1, 15, 16'h0450, 0, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 15, 2);
    #1;
    check("t1_a_rout1", 32'(ifa.Rout1), 32'h0450);
    check("t1_a_rout2", 32'(ifa.Rout2), 0);
    check("t1_a_cnt", 32'(ifa.pend_cnt), 0);
    check("t1_b_rout1", 32'(ifb.Rout1), 32'h0450);

    // 2: R0 suppression; dut_b treats R0 as an ordinary register
    drv(1, 0, 16'h1254, 1, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t2_a_rout1", 32'(ifa.Rout1), 0);
    check("t2_a_busy1", 32'(ifa.busy1), 0);
    check("t2_a_cnt", 32'(ifa.pend_cnt), 0);
    check("t2_b_rout1", 32'(ifb.Rout1), 32'h1254);
    check("t2_b_busy1", 32'(ifb.busy1), 1);
    check("t2_b_cnt", 32'(ifb.pend_cnt), 1);
    drv(1, 0, 16'h1254, 0, 0, 0, 0);          // retire dut_b's R0
    cycle();
    drv(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t2_b_cnt_ret", 32'(ifb.pend_cnt), 0);

    // 3: bypass versus no bypass
    drv(1, 9, 16'h3347, 0, 0, 9, 1);
    #1;
    check("t3_a_byp", 32'(ifa.Rout1), 32'h3347);
    check("t3_b_nobyp", 32'(ifb.Rout1), 0);
    cycle();
    drv(0, 0, 0, 0, 0, 9, 1);
    #1;
    check("t3_a_after", 32'(ifa.Rout1), 32'h3347);
    check("t3_b_after", 32'(ifb.Rout1), 32'h3347);

    // 4: scoreboard on R3 and R5
    drv(0, 0, 0, 1, 3, 0, 0);
    cycle();
    drv(0, 0, 0, 1, 5, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 3, 5);
    #1;
    check("t4_cnt2", 32'(ifa.pend_cnt), 2);
    check("t4_busy1", 32'(ifa.busy1), 1);
    check("t4_busy2", 32'(ifa.busy2), 1);
    check("t4_hazard", 32'(ifa.hazard), 1);
    drv(1, 3, 16'h0033, 0, 0, 3, 5);
    #1;
    check("t4_busy_retiring", 32'(ifa.busy1), 1);   // bypass does not mask busy
    check("t4_byp_retiring", 32'(ifa.Rout1), 32'h0033);
    cycle();
    drv(0, 0, 0, 0, 0, 3, 5);
    #1;
    check("t4_busy1_clr", 32'(ifa.busy1), 0);
    check("t4_cnt1", 32'(ifa.pend_cnt), 1);
    check("t4_hazard_r5", 32'(ifa.hazard), 1);
    drv(1, 5, 16'h0055, 0, 0, 3, 5);
    cycle();
    drv(0, 0, 0, 0, 0, 3, 5);
    #1;
    check("t4_hazard_clr", 32'(ifa.hazard), 0);
    check("t4_cnt0", 32'(ifa.pend_cnt), 0);

    // 5: simultaneous issue and write
    drv(0, 0, 0, 1, 7, 7, 4);
    cycle();
    drv(1, 7, 16'h7777, 1, 7, 7, 4);          // same register: it stays pending
    cycle();
    drv(0, 0, 0, 0, 0, 7, 4);
    #1;
    check("t5_cnt_same", 32'(ifa.pend_cnt), 1);
    check("t5_busy_same", 32'(ifa.busy1), 1);
    check("t5_data_same", 32'(ifa.Rout1), 32'h7777);
    drv(1, 7, 16'h7778, 1, 4, 7, 4);          // R4 is set and R7 is cleared
    cycle();
    drv(0, 0, 0, 0, 0, 7, 4);
    #1;
    check("t5_cnt_swap", 32'(ifa.pend_cnt), 1);
    check("t5_r7_free", 32'(ifa.busy1), 0);
    check("t5_r4_busy", 32'(ifa.busy2), 1);
    drv(0, 0, 0, 1, 4, 7, 4);                 // re-issue to a register that is already pending
    cycle();
    drv(1, 9, 16'h9999, 0, 0, 9, 4);          // write to a register that is not pending
    cycle();
    drv(0, 0, 0, 0, 0, 9, 4);
    #1;
    check("t5_cnt_reissue", 32'(ifa.pend_cnt), 1);
    check("t5_nonpend_wr", 32'(ifa.Rout1), 32'h9999);
    check("t5_nonpend_busy", 32'(ifa.busy1), 0);

    // 6: asynchronous reset mid-operation, then fill every register
    drv(0, 0, 0, 1, 1, 15, 4);
    cycle();
    drv(0, 0, 0, 1, 2, 15, 4);
    cycle();
    drv(0, 0, 0, 0, 0, 15, 4);
    #1;
    check("t6_cnt3", 32'(ifa.pend_cnt), 3);
    check("t6_pre_data", 32'(ifa.Rout1), 32'h0450);
    rst = 1'b0;                               // between edges
    #1;
    check("t6_rst_rout1", 32'(ifa.Rout1), 0);
    check("t6_rst_rout2", 32'(ifa.Rout2), 0);
    check("t6_rst_cnt", 32'(ifa.pend_cnt), 0);
    check("t6_rst_hazard", 32'(ifa.hazard), 0);
    check("t6_rst_b_data", 32'(ifb.Rout1), 0);
    #1 rst = 1'b1;
    for (int i = 1; i < 16; i++) begin
      drv(0, 0, 0, 1, 4'(i), 0, 0);
      cycle();
    end
    drv(0, 0, 0, 0, 0, 0, 15);
    #1;
    check("t6_a_fill15", 32'(ifa.pend_cnt), 15);
    check("t6_a_r0_busy", 32'(ifa.busy1), 0);
    check("t6_a_r15_busy", 32'(ifa.busy2), 1);
    drv(0, 0, 0, 1, 0, 0, 15);                // R0: ignored by dut_a, counted by dut_b
    cycle();
    drv(0, 0, 0, 0, 0, 0, 15);
    #1;
    check("t6_a_r0_issue", 32'(ifa.pend_cnt), 15);
    check("t6_b_full16", 32'(ifb.pend_cnt), 16);
    check("t6_b_r0_busy", 32'(ifb.busy1), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file for the RISC core. It generalises the fixed 16x16 two-read/one-write file in three ways: configurable width and depth, an optional hardwired-zero R0, and optional write-to-read bypass. It also adds a per-register pending-write scoreboard with hazard flags and an outstanding-write counter. It sits between decode (read and issue side) and writeback (write side).

Parameters:
DW, 16, data width of each register
AW, 4, address width; depth = 2**AW registers
ZERO_R0, 1, 1 = register 0 always reads 0, writes and issues to it are ignored
BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that read output

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
Rs  in  AW  read address, port 1
Rt  in  AW  read address, port 2
Rd  in  AW  write address
RW  in  DW  write data
wr  in  1  write enable; also retires the pending flag of Rd
issue  in  1  decode issues an instruction that will later write issue_rd
issue_rd  in  AW  destination register of the issued instruction
Rout1  out  DW  read data for Rs
Rout2  out  DW  read data for Rt
busy1  out  1  Rs has an outstanding write
busy2  out  1  Rt has an outstanding write
hazard  out  1  busy1 | busy2
pend_cnt  out  AW+1  number of registers currently pending

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all pending flags = 0, pend_cnt = 0. Outputs are therefore Rout1 = Rout2 = 0, busy1 = busy2 = hazard = 0. Reset asserted mid-operation discards pending state immediately. Writes and issues in the cycle rst deasserts are honoured at the next edge.
- Reads: combinational from Rs/Rt. With ZERO_R0=1, address 0 reads 0.
- Bypass: with BYPASS=1, if wr=1 and Rd==Rs (resp. Rt) and Rd is not a suppressed R0, then Rout1 (resp. Rout2) = RW in the same cycle. With BYPASS=0, the new value is visible only after the edge.
- Write: on a rising edge with wr=1, reg[Rd] <= RW. Suppressed when Rd==0 and ZERO_R0=1.
- Scoreboard, one pending bit per register, updated at the rising edge:
  - issue=1 sets pend[issue_rd].
  - wr=1 clears pend[Rd].
  - issue and wr to the same register in one cycle: pend stays 1, because the new producer owns it.
  - wr to a register that is not pending: the write happens and pend stays 0 (no error).
  - issue to a register that is already pending: it stays pending; the counter does not change.
  - With ZERO_R0=1, R0 is never pending.
- busy1 = pend[Rs], busy2 = pend[Rt], combinational.
  - Bypass does not mask busy. A register being retired this cycle still shows busy until the edge.
  - With ZERO_R0=1, busy for address 0 is 0.
- pend_cnt always equals the popcount of pend. It is updated by +1 / -1 / 0 per edge according to the net change in set bits, and it saturates naturally at 2**AW because only distinct bits are counted.
- All widths are exact; RW is stored unmodified. No X-propagation is allowed on outputs after reset.

Test Plan:
1. Reset, then write: assert rst=0 for 35 ns, release, then wr=1, Rd=15, RW=16'h0450 for one edge. Set wr=0, Rs=15, Rt=2 -> Rout1=16'h0450, Rout2=0, pend_cnt=0.
2. R0 suppression: with ZERO_R0=1, wr=1, Rd=0, RW=16'h1254, then issue=1, issue_rd=0 -> Rout1 (Rs=0) = 0, busy1=0, pend_cnt=0. With ZERO_R0=0 in a second instance, Rout1=16'h1254.
3. Bypass: wr=1, Rd=9, RW=16'h3347, Rs=9 in the same cycle before the edge -> Rout1=16'h3347 with BYPASS=1; Rout1 = old value (0) with BYPASS=0; both show 16'h3347 after the edge.
4. Scoreboard: issue to 3, then issue to 5 -> pend_cnt=2. Set Rs=3, Rt=5 -> busy1=busy2=hazard=1. Then wr Rd=3 -> busy1=0, pend_cnt=1. Then wr Rd=5 -> hazard=0, pend_cnt=0.
5. Simultaneous events: pend[7]=1, then issue_rd=7 with wr Rd=7 in the same cycle -> pend[7] stays 1, pend_cnt unchanged, reg[7] updated. Next, issue_rd=4 with wr Rd=7 -> pend_cnt unchanged (one set, one cleared).
6. Reset mid-operation: three registers pending plus register data present, pulse rst low asynchronously between edges -> outputs immediately 0, pend_cnt=0, hazard=0. Fill all 15 non-zero registers as pending -> pend_cnt=15.
